// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param
// Parametrised SAR ADC sequencer. It samples the input once per conversion,
// then runs an NBITS-step binary search on the CDAC and reports the
// parallel result with a one-cycle valid pulse. It can run single-shot
// or back-to-back (continuous).
//
// Ports
//   CLK          PLL clock; all state changes on the rising edge
//   XRST         asynchronous reset, active-low
//   START        level; a conversion begins when seen in IDLE or DONE
//   CONT         continuous mode; seen in DONE
//   COMP_OUT     latched comparator decision
//   COMP_CLK     comparator clock
//   SC           top-plate-to-GND sample switch, 1 = closed
//   SDAC         bottom-plate switches, 1 = Vref; [NBITS] = largest cap,
//                [0] = terminating unit cap (always 0)
//   DIGITAL_OUT  most recent bit decision (serial, MSB first)
//   DATA_OUT     last completed result
//   DATA_VALID   one-cycle pulse when DATA_OUT updates
//   BUSY         high while sampling, settling or comparing
//   OVR          (SAR_OVR_EN only) sticky flag: START arrived while busy
//
// Build option: define SAR_OVR_EN to add the OVR port and overrun logic.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for START, sample switch closed
// SAMPLE   | T_SAMP cycles tracking the input on the top plate
// SETTLE   | T_SETTLE cycles letting the CDAC settle for trial bit k
// COMPARE  | T_COMP cycles with COMP_CLK high, decision on the last edge
// DONE     | one cycle, DATA_VALID high; restart if CONT or START

module sar_ctrl_param #(
    parameter int NBITS    = 8,
    parameter int T_SAMP   = 2,
    parameter int T_SETTLE = 2,
    parameter int T_COMP   = 2
) (
    input  logic             CLK,
    input  logic             XRST,
    input  logic             START,
    input  logic             CONT,
    input  logic             COMP_OUT,
    output logic             COMP_CLK,
    output logic             SC,
    output logic [NBITS:0]   SDAC,
    output logic             DIGITAL_OUT,
    output logic [NBITS-1:0] DATA_OUT,
    output logic             DATA_VALID,
    output logic             BUSY
`ifdef SAR_OVR_EN
    ,
    output logic             OVR
`endif
);

    localparam int TMAX = (T_SAMP > T_SETTLE) ? ((T_SAMP > T_COMP) ? T_SAMP : T_COMP)
                                              : ((T_SETTLE > T_COMP) ? T_SETTLE : T_COMP);
    localparam int CW = $clog2(TMAX + 1);
    localparam int KW = $clog2(NBITS);

    localparam logic [CW-1:0] C_SAMP   = CW'(T_SAMP - 1);
    localparam logic [CW-1:0] C_SETTLE = CW'(T_SETTLE - 1);
    localparam logic [CW-1:0] C_COMP   = CW'(T_COMP - 1);
    localparam logic [KW-1:0] K_MSB    = KW'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [KW-1:0]    r_k, w_k_nxt;
    logic [NBITS-1:0] r_res, w_res_nxt;
    logic [NBITS:0]   r_sdac, w_sdac_nxt;
    logic [NBITS-1:0] r_data, w_data_nxt;
    logic             r_sc, w_sc_nxt;
    logic             r_comp_clk, w_comp_clk_nxt;
    logic             r_dig, w_dig_nxt;
    logic             r_dv, w_dv_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_cnt_zero;
    logic [CW-1:0]    w_cnt_dec;

    // Phase timers are down-counters loaded with T-1 on phase entry;
    // the phase ends on the edge where the count is zero.
    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = r_cnt - CW'(1);

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (START) w_state_nxt = S_SAMPLE;
            S_SAMPLE:  if (w_cnt_zero) w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_cnt_zero) w_state_nxt = S_COMPARE;
            S_COMPARE: if (w_cnt_zero) w_state_nxt = (r_k == '0) ? S_DONE : S_SETTLE;
            S_DONE:    w_state_nxt = (CONT || START) ? S_SAMPLE : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_k_nxt        = r_k;
        w_res_nxt      = r_res;
        w_sdac_nxt     = r_sdac;
        w_data_nxt     = r_data;
        w_sc_nxt       = r_sc;
        w_comp_clk_nxt = r_comp_clk;
        w_dig_nxt      = r_dig;
        w_dv_nxt       = 1'b0;
        w_busy_nxt     = r_busy;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_cnt_nxt  = C_SAMP;
                    w_busy_nxt = 1'b1;
                end
            end
            S_SAMPLE: begin
                if (w_cnt_zero) begin
                    w_sc_nxt          = 1'b0;
                    w_sdac_nxt[NBITS] = 1'b1;
                    w_k_nxt           = K_MSB;
                    w_cnt_nxt         = C_SETTLE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_SETTLE: begin
                if (w_cnt_zero) begin
                    w_comp_clk_nxt = 1'b1;
                    w_cnt_nxt      = C_COMP;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_COMPARE: begin
                if (w_cnt_zero) begin
                    w_comp_clk_nxt = 1'b0;
                    w_dig_nxt      = COMP_OUT;
                    // Resolve trial k (switch k+1) and raise the next trial switch.
                    for (int i = 0; i < NBITS; i++) begin
                        if (KW'(i) == r_k) begin
                            w_res_nxt[i]    = COMP_OUT;
                            w_sdac_nxt[i+1] = COMP_OUT;
                            if (i > 0) w_sdac_nxt[i] = 1'b1;
                        end
                    end
                    if (r_k == '0) begin
                        w_data_nxt = w_res_nxt;
                        w_dv_nxt   = 1'b1;
                        w_busy_nxt = 1'b0;
                        w_sc_nxt   = 1'b1;
                        w_sdac_nxt = '0;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_k_nxt   = r_k - KW'(1);
                        w_cnt_nxt = C_SETTLE;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_DONE: begin
                if (CONT || START) begin
                    w_cnt_nxt  = C_SAMP;
                    w_busy_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        // Unit terminating cap never switches to Vref.
        w_sdac_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            r_cnt      <= '0;
            r_k        <= K_MSB;
            r_res      <= '0;
            r_sdac     <= '0;
            r_data     <= '0;
            r_sc       <= 1'b1;
            r_comp_clk <= 1'b0;
            r_dig      <= 1'b0;
            r_dv       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_k        <= w_k_nxt;
            r_res      <= w_res_nxt;
            r_sdac     <= w_sdac_nxt;
            r_data     <= w_data_nxt;
            r_sc       <= w_sc_nxt;
            r_comp_clk <= w_comp_clk_nxt;
            r_dig      <= w_dig_nxt;
            r_dv       <= w_dv_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign COMP_CLK    = r_comp_clk;
    assign SC          = r_sc;
    assign SDAC        = r_sdac;
    assign DIGITAL_OUT = r_dig;
    assign DATA_OUT    = r_data;
    assign DATA_VALID  = r_dv;
    assign BUSY        = r_busy;

`ifdef SAR_OVR_EN
    logic r_ovr;

    // Set and clear come from disjoint states, so their order is irrelevant.
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            r_ovr <= 1'b0;
        end else if (START) begin
            if (r_state == S_IDLE)
                r_ovr <= 1'b0;
            else if (r_state == S_SAMPLE || r_state == S_SETTLE || r_state == S_COMPARE)
                r_ovr <= 1'b1;
        end
    end

    assign OVR = r_ovr;
`endif

endmodule

// File: tb/tb_sar_ctrl_param.sv
module tb_sar_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       xrst  = 1'b0;
    logic       start = 1'b0;
    logic       cont  = 1'b0;
    logic [7:0] vin   = 8'h00;
    wire        comp_out_a;
    logic       comp_clk, sc, dig, dv, busy;
    logic [8:0] sdac;
    logic [7:0] dout;

    logic        start_b = 1'b0;
    logic [9:0]  vin_b   = 10'h2AA;
    wire         comp_out_b;
    logic        comp_clk_b, sc_b, dig_b, dv_b, busy_b;
    logic [10:0] sdac_b;
    logic [9:0]  dout_b;

`ifdef SAR_OVR_EN
    logic ovr, ovr_b;
`endif

    // Ideal comparator: keep the trial when the DAC code does not exceed Vin.
    assign comp_out_a = (sdac[8:1] <= vin);
    assign comp_out_b = (sdac_b[10:1] <= vin_b);

    sar_ctrl_param dut_a (
        .CLK(clk), .XRST(xrst), .START(start), .CONT(cont), .COMP_OUT(comp_out_a),
        .COMP_CLK(comp_clk), .SC(sc), .SDAC(sdac), .DIGITAL_OUT(dig),
        .DATA_OUT(dout), .DATA_VALID(dv), .BUSY(busy)
`ifdef SAR_OVR_EN
        , .OVR(ovr)
`endif
    );

    sar_ctrl_param #(.NBITS(10), .T_SAMP(3), .T_SETTLE(1), .T_COMP(1)) dut_b (
        .CLK(clk), .XRST(xrst), .START(start_b), .CONT(1'b0), .COMP_OUT(comp_out_b),
        .COMP_CLK(comp_clk_b), .SC(sc_b), .SDAC(sdac_b), .DIGITAL_OUT(dig_b),
        .DATA_OUT(dout_b), .DATA_VALID(dv_b), .BUSY(busy_b)
`ifdef SAR_OVR_EN
        , .OVR(ovr_b)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    int         cc_high;
    logic [7:0] seq;
    logic       sdac0_bad = 1'b0;
    logic       first_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge after the accepting edge (or in DONE for
    // back-to-back). Counts rising edges until DATA_VALID is seen.
    task automatic wait_dv_a(input int glitch_at, input int drop_cont_at, output int edges);
        logic prev_cc;
        edges      = 0;
        cc_high    = 0;
        seq        = 8'h00;
        first_busy = 1'b0;
        prev_cc    = comp_clk;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) first_busy = busy;
            if (comp_clk) cc_high++;
            if (prev_cc && !comp_clk) seq = {seq[6:0], dig};
            prev_cc = comp_clk;
            if (sdac[0]) sdac0_bad = 1'b1;
            start = (edges == glitch_at);
            if (edges == drop_cont_at) cont = 1'b0;
            if (dv) break;
        end
        chk("dv_seen", dv, 1);
    endtask

    task automatic start_pulse_a();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0] edge_vec [2];

    initial begin
        int lat;
        edge_vec[0] = 8'h00;
        edge_vec[1] = 8'hFF;

        @(negedge clk);
        chk("rst_sc", sc, 1);
        chk("rst_sdac", sdac, 0);
        chk("rst_comp_clk", comp_clk, 0);
        chk("rst_dig", dig, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dv", dv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_b_sc", sc_b, 1);
        chk("rst_b_dout", dout_b, 0);
`ifdef SAR_OVR_EN
        chk("rst_ovr", ovr, 0);
`endif
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);

        // Single shot 0xA5
        vin = 8'hA5;
        start_pulse_a();
        chk("a5_busy", busy, 1);
        wait_dv_a(-1, -1, lat);
        chk("a5_latency", lat, 34);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_serial", seq, 8'hA5);
        chk("a5_cc_high", cc_high, 16);
        chk("a5_busy_done", busy, 0);
        chk("a5_sc_done", sc, 1);
        chk("a5_sdac_done", sdac, 0);
        @(negedge clk);
        chk("a5_dv_pulse", dv, 0);
        chk("a5_idle_sc", sc, 1);
        @(negedge clk);
        chk("a5_idle_busy", busy, 0);
        chk("a5_idle_sdac", sdac, 0);

        // Rail codes
        for (int i = 0; i < 2; i++) begin
            vin = edge_vec[i];
            start_pulse_a();
            wait_dv_a(-1, -1, lat);
            chk("rail_dout", dout, edge_vec[i]);
            chk("rail_serial", seq, edge_vec[i]);
            chk("rail_cc_high", cc_high, 16);
            @(negedge clk);
            @(negedge clk);
        end
        chk("sdac0_zero", sdac0_bad, 0);

        // Continuous mode, START glitch mid-conversion, CONT dropped mid-conversion
        cont = 1'b1;
        vin  = 8'h3C;
        start_pulse_a();
        wait_dv_a(10, -1, lat);
        chk("cont1_latency", lat, 34);
        chk("cont1_dout", dout, 8'h3C);
        chk("cont1_serial", seq, 8'h3C);
`ifdef SAR_OVR_EN
        chk("ovr_set", ovr, 1);
`endif
        vin = 8'hC3;
        wait_dv_a(-1, 10, lat);
        chk("cont2_period", lat, 35);
        chk("cont2_no_idle", first_busy, 1);
        chk("cont2_dout", dout, 8'hC3);
        chk("cont2_serial", seq, 8'hC3);
        @(negedge clk);
        @(negedge clk);
        chk("cont_stop_busy", busy, 0);
        chk("dout_hold", dout, 8'hC3);

        // Reset mid-conversion
        vin = 8'h5A;
        start_pulse_a();
`ifdef SAR_OVR_EN
        chk("ovr_clear", ovr, 0);
`endif
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        #1 xrst = 1'b0;
        #1;
        chk("arst_sc", sc, 1);
        chk("arst_sdac", sdac, 0);
        chk("arst_comp_clk", comp_clk, 0);
        chk("arst_dig", dig, 0);
        chk("arst_dout", dout, 0);
        chk("arst_dv", dv, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        start_pulse_a();
        wait_dv_a(-1, -1, lat);
        chk("post_rst_latency", lat, 34);
        chk("post_rst_dout", dout, 8'h5A);
        @(negedge clk);

        // 10-bit instance, short phases
        begin
            int eb;
            eb = 0;
            start_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_b = 1'b0;
            while (eb < 200 && !dv_b) begin
                @(posedge clk);
                eb++;
                @(negedge clk);
            end
            chk("b_dv_seen", dv_b, 1);
            chk("b_latency", eb, 23);
            chk("b_dout", dout_b, 10'h2AA);
            chk("b_sc_done", sc_b, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar_ctrl_param.md
Name: sar_ctrl_param

Overview:
Parametrised SAR ADC controller. Drives comparator clock, CDAC sample switch and CDAC switch array for an NBITS-bit binary search. Sampling happens once per conversion. Timing per phase is set by parameters. Outputs the parallel result with a valid pulse and supports single-shot or continuous mode; sits between the PLL clock domain and the analog comparator/CDAC macro.

Parameters:
NBITS, 8, resolution; CDAC has NBITS+1 switches (legal 2..16)
T_SAMP, 2, CLK cycles per conversion with SC high (sampling), >=1
T_SETTLE, 2, CLK cycles of CDAC settling per bit before comparator clock, >=1
T_COMP, 2, CLK cycles COMP_CLK held high per bit, >=1

Ports:
CLK  in  1  PLL clock, all state on rising edge
XRST  in  1  asynchronous reset, active-low
START  in  1  level; sampled in IDLE or DONE to begin a conversion
CONT  in  1  continuous mode; sampled in DONE
COMP_OUT  in  1  latched comparator result, stable while COMP_CLK low
COMP_CLK  out  1  comparator clock
SC  out  1  CDAC top-plate-to-GND switch, high = closed
SDAC  out  NBITS+1  CDAC bottom-plate switches, 1 = Vref; [NBITS] = largest cap
DIGITAL_OUT  out  1  most recent bit decision (serial stream, MSB first)
DATA_OUT  out  NBITS  last completed conversion result
DATA_VALID  out  1  one-cycle pulse, DATA_OUT updated
BUSY  out  1  high in SAMPLE/SETTLE/COMPARE

Behaviour:
- Reset (XRST low, async, any state): state IDLE; SC=1, SDAC=0, COMP_CLK=0, DIGITAL_OUT=0, DATA_OUT=0, DATA_VALID=0, BUSY=0, bit index k=NBITS-1, all counters 0.
- All outputs registered.
- SDAC[0] is the terminating unit cap and is held 0 always. Trial for result bit k drives SDAC[k+1].
- IDLE: SC=1, SDAC=0, COMP_CLK=0. START=1 at an edge -> SAMPLE, BUSY=1.
- SAMPLE: SC=1, SDAC=0 for T_SAMP cycles. At the last edge: SC<=0, SDAC[NBITS]<=1, k=NBITS-1 -> SETTLE.
- SETTLE: T_SETTLE cycles, COMP_CLK=0. At the last edge: COMP_CLK<=1 -> COMPARE.
- COMPARE: T_COMP cycles. At the last edge, COMP_OUT is sampled:
  - result[k]<=COMP_OUT; DIGITAL_OUT<=COMP_OUT; SDAC[k+1]<=COMP_OUT (0 clears the trial, 1 keeps it); COMP_CLK<=0.
  - If k>0: SDAC[k]<=1, k<=k-1 -> SETTLE.
  - If k==0: DATA_OUT<=full result, DATA_VALID<=1, BUSY<=0, SC<=1, SDAC<=0 -> DONE.
- DONE: one cycle; DATA_VALID deasserts at its end. If CONT=1 or START=1 -> SAMPLE (back-to-back, no IDLE cycle); else -> IDLE.
- Latency: DATA_VALID rises T_SAMP + NBITS*(T_SETTLE+T_COMP) edges after the edge accepting START. Defaults: 34.
- Conversion period in continuous mode: latency+1 cycles. Defaults: 35.
- START during SAMPLE/SETTLE/COMPARE is ignored; the conversion in flight is never restarted.
- CONT deasserted mid-conversion: the current conversion completes, then IDLE (unless START=1 in DONE).
- DATA_OUT holds until the next DATA_VALID; it is never partially updated.
- Reset mid-conversion: immediate return to reset values; partial result discarded; DATA_OUT cleared.
- Counters: phase counter width clog2(max(T_SAMP,T_SETTLE,T_COMP)+1); k width clog2(NBITS); no wrap beyond terminal counts.

Optional Feature:
SAR_OVR_EN
- Defined: adds output port OVR (1 bit, reset 0).
  - OVR is set (sticky) when START=1 at an edge while in SAMPLE/SETTLE/COMPARE.
  - Cleared when START is accepted from IDLE.
  - A set and a clear in the same cycle cannot occur; there is no priority conflict.
- Not defined: no OVR port, no overrun logic; START while busy is silently ignored.

Test Plan:
- Defaults; comparator model COMP_OUT = (DAC code <= 0xA5); pulse START once -> DATA_VALID at edge 34, DATA_OUT=0xA5, DIGITAL_OUT sequence 1,0,1,0,0,1,0,1, then IDLE with SC=1, SDAC=0.
- Vin codes 0x00 and 0xFF -> DATA_OUT 0x00 / 0xFF; SDAC[0]=0 throughout; COMP_CLK high exactly 8 x 2 cycles per conversion.
- CONT=1 held, Vin steps 0x3C then 0xC3 -> DATA_VALID every 35 cycles, results 0x3C, 0xC3, no IDLE cycle between.
- XRST low at cycle 20 of a conversion -> all outputs at reset values the same cycle (async), DATA_OUT=0; after release, START gives a correct result.
- NBITS=10, T_SAMP=3, T_SETTLE=1, T_COMP=1, Vin 0x2AA -> DATA_VALID at edge 23, DATA_OUT=0x2AA.
- SAR_OVR_EN defined: START pulsed at cycle 10 of a conversion -> OVR=1, result unaffected; next START from IDLE -> OVR=0.
